// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rsa_pkg
// Purpose  : Shared constants for the modexp MMIO bridge. Holds the window
//            offsets, the CTRL/STATUS bit positions and the bridge FSM states.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rsa_pkg;

  // Window offsets within the 11-bit decoded address space
  localparam logic [10:0] OFS_M    = 11'h000;
  localparam logic [10:0] OFS_E    = 11'h100;
  localparam logic [10:0] OFS_N    = 11'h200;
  localparam logic [10:0] OFS_C    = 11'h300;
  localparam logic [10:0] OFS_CTRL = 11'h400;
  localparam logic [10:0] OFS_CYC  = 11'h404;

  // CTRL write bit positions
  localparam int CTRL_GO       = 0;
  localparam int CTRL_IE       = 1;
  localparam int CTRL_DONE_CLR = 2;
  localparam int CTRL_ERR_CLR  = 3;

  // STATUS read bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;
  localparam int STAT_IE   = 3;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_ISSUE = 2'd1,
    STATE_WLOW  = 2'd2,
    STATE_WHIGH = 2'd3
  } state_t;

endpackage : rsa_pkg
`default_nettype wire

// File: rtl/wide_byte_reg.sv
`default_nettype none
// ============================================================================
// Module   : wide_byte_reg
// Purpose  : W-bit register addressed as little-endian bytes. Supports a
//            single-byte write, a full-width parallel load (load wins), and
//            a combinational byte read mux. Byte indices >= W/8 read 0x00
//            and are never written.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            idx           - byte index (byte k = bits [8k+7:8k])
//            wdata, we     - byte write data / enable
//            load,load_data- full-width parallel load
//            q             - current register value
//            rdata         - byte selected by idx
// Revision : 1.0 - initial release
// ============================================================================
module wide_byte_reg #(
  parameter int W = 2048
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   idx,
  input  logic [7:0]   wdata,
  input  logic         we,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] q,
  output logic [7:0]   rdata
);

  localparam int NB = W / 8;

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_data;
    end else if (we) begin
      // Out-of-range indices match no byte, so the write is dropped
      for (int k = 0; k < NB; k++) begin
        if (idx == 8'(k)) r_q[8*k +: 8] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    for (int k = 0; k < NB; k++) begin
      if (idx == 8'(k)) rdata = r_q[8*k +: 8];
    end
  end

  assign q = r_q;

endmodule : wide_byte_reg
`default_nettype wire

// File: rtl/rsa_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : rsa_mmio_bridge
// Purpose  : Byte-wide XRAM front end for the modexp engine. Firmware loads
//            m/e/n byte by byte, sets GO; the bridge pulses mx_start, waits
//            for mx_ready to fall and rise again, captures mx_c into C and
//            raises DONE (irq = DONE & IE). CYC counts busy cycles.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            addr, wr, wdata   - byte write port
//            rd, rdata         - byte read port (rdata registered)
//            irq               - level interrupt
//            mx_start/mx_ready - modexp handshake
//            mx_m/e/n, mx_c    - modexp operands and result
// Revision : 1.0 - initial release
// ============================================================================
module rsa_mmio_bridge
  import rsa_pkg::*;
#(
  parameter int W      = 2048,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic [7:0]        wdata,
  input  logic              rd,
  output logic [7:0]        rdata,
  output logic              irq,
  output logic              mx_start,
  input  logic              mx_ready,
  output logic [W-1:0]      mx_m,
  output logic [W-1:0]      mx_e,
  output logic [W-1:0]      mx_n,
  input  logic [W-1:0]      mx_c
);

  localparam int NB = W / 8;

  state_t      r_state, w_state_nxt;
  logic        r_ie, r_done, r_err;
  logic [31:0] r_cyc;

  logic        w_hi_zero;
  logic [10:0] w_off;
  logic [7:0]  w_idx;
  logic        w_in_range;
  logic        w_sel_m, w_sel_e, w_sel_n, w_sel_c, w_sel_ctrl, w_sel_cyc;
  logic        w_busy, w_op_wr, w_ctrl_wr, w_go, w_start, w_err_set, w_complete;
  logic [7:0]  w_m_byte, w_e_byte, w_n_byte, w_c_byte, w_rd_byte;
  logic [W-1:0] w_c_q;

  // Offsets above the 11-bit window alias nothing
  generate
    if (ADDR_W > 11) begin : g_hi_chk
      assign w_hi_zero = (addr[ADDR_W-1:11] == '0);
    end else begin : g_hi_none
      assign w_hi_zero = 1'b1;
    end
  endgenerate

  assign w_off      = addr[10:0];
  assign w_idx      = w_off[7:0];
  assign w_in_range = ({1'b0, w_idx} < 9'(NB));

  assign w_sel_m    = w_hi_zero && (w_off[10:8] == OFS_M[10:8]);
  assign w_sel_e    = w_hi_zero && (w_off[10:8] == OFS_E[10:8]);
  assign w_sel_n    = w_hi_zero && (w_off[10:8] == OFS_N[10:8]);
  assign w_sel_c    = w_hi_zero && (w_off[10:8] == OFS_C[10:8]);
  assign w_sel_ctrl = w_hi_zero && (w_off == OFS_CTRL);
  assign w_sel_cyc  = w_hi_zero && (w_off[10:2] == OFS_CYC[10:2]);

  assign w_busy     = (r_state != STATE_IDLE);
  assign w_op_wr    = wr && !w_busy && w_in_range;
  assign w_ctrl_wr  = wr && w_sel_ctrl;
  assign w_go       = w_ctrl_wr && wdata[CTRL_GO];
  assign w_start    = w_go && !w_busy;
  // Operand writes or GO while busy are rejected and flagged
  assign w_err_set  = w_busy && ((wr && (w_sel_m || w_sel_e || w_sel_n)) || w_go);
  assign w_complete = (r_state == STATE_WHIGH) && mx_ready;

  wide_byte_reg #(.W(W)) u_m (
    .clk(clk), .rst(rst), .idx(w_idx), .wdata(wdata), .we(w_op_wr && w_sel_m),
    .load(1'b0), .load_data('0), .q(mx_m), .rdata(w_m_byte)
  );
  wide_byte_reg #(.W(W)) u_e (
    .clk(clk), .rst(rst), .idx(w_idx), .wdata(wdata), .we(w_op_wr && w_sel_e),
    .load(1'b0), .load_data('0), .q(mx_e), .rdata(w_e_byte)
  );
  wide_byte_reg #(.W(W)) u_n (
    .clk(clk), .rst(rst), .idx(w_idx), .wdata(wdata), .we(w_op_wr && w_sel_n),
    .load(1'b0), .load_data('0), .q(mx_n), .rdata(w_n_byte)
  );
  // Result register: read-only from the bus, loaded on completion
  wide_byte_reg #(.W(W)) u_c (
    .clk(clk), .rst(rst), .idx(w_idx), .wdata(8'h00), .we(1'b0),
    .load(w_complete), .load_data(mx_c), .q(w_c_q), .rdata(w_c_byte)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= STATE_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and outputs
  always_comb begin
    w_state_nxt = r_state;
    mx_start    = 1'b0;
    case (r_state)
      STATE_IDLE:  if (w_start) w_state_nxt = STATE_ISSUE;
      STATE_ISSUE: begin
        mx_start    = 1'b1;
        w_state_nxt = STATE_WLOW;
      end
      STATE_WLOW:  if (!mx_ready) w_state_nxt = STATE_WHIGH;
      STATE_WHIGH: if (mx_ready)  w_state_nxt = STATE_IDLE;
      default:     w_state_nxt = STATE_IDLE;
    endcase
  end

  // Control / status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_cyc  <= '0;
    end else begin
      if (w_ctrl_wr) r_ie <= wdata[CTRL_IE];

      if (w_complete)
        r_done <= 1'b1;
      else if (w_start || (w_ctrl_wr && wdata[CTRL_DONE_CLR]))
        r_done <= 1'b0;

      // Clear wins over a same-write GO-while-busy error
      if (w_ctrl_wr && wdata[CTRL_ERR_CLR]) r_err <= 1'b0;
      else if (w_err_set)                   r_err <= 1'b1;

      if (w_start)                            r_cyc <= '0;
      else if (w_busy && (r_cyc != '1))       r_cyc <= r_cyc + 32'd1;
    end
  end

  // Read mux; registered below so rd sees pre-write values
  always_comb begin
    w_rd_byte = 8'h00;
    if (w_sel_m)         w_rd_byte = w_m_byte;
    else if (w_sel_e)    w_rd_byte = w_e_byte;
    else if (w_sel_n)    w_rd_byte = w_n_byte;
    else if (w_sel_c)    w_rd_byte = w_c_byte;
    else if (w_sel_ctrl) w_rd_byte = {4'b0000, r_ie, r_err, r_done, w_busy};
    else if (w_sel_cyc)  w_rd_byte = r_cyc[8*w_off[1:0] +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= 8'h00;
    else if (rd) rdata <= w_rd_byte;
  end

  assign irq = r_done && r_ie;

endmodule : rsa_mmio_bridge
`default_nettype wire

// File: tb/tb_rsa_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_mmio_bridge
// Purpose  : Directed self-checking bench for rsa_mmio_bridge at W=16 with a
//            behavioural modexp model of programmable latency.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_mmio_bridge;

  localparam int W      = 16;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic              wr = 1'b0;
  logic [7:0]        wdata = 8'h00;
  logic              rd = 1'b0;
  logic [7:0]        rdata;
  logic              irq;
  logic              mx_start;
  logic              mx_ready;
  logic [W-1:0]      mx_m, mx_e, mx_n, mx_c;

  int tests_run    = 0;
  int tests_failed = 0;
  int start_cnt    = 0;
  int lat          = 5;
  int mcnt;
  logic [W-1:0] m_res;

  rsa_mmio_bridge #(.W(W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .wdata(wdata),
    .rd(rd), .rdata(rdata), .irq(irq), .mx_start(mx_start),
    .mx_ready(mx_ready), .mx_m(mx_m), .mx_e(mx_e), .mx_n(mx_n), .mx_c(mx_c)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] n);
    longint r = 1;
    longint x = b % n;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % n;
      x = (x * x) % n;
    end
    return W'(r);
  endfunction

  // Behavioural modexp: ready drops after start, rises lat cycles after start
  always @(posedge clk) begin
    if (rst) begin
      mx_ready <= 1'b1;
      mx_c     <= '0;
      mcnt     <= 0;
    end else if (mx_start) begin
      mx_ready <= 1'b0;
      mcnt     <= lat - 1;
      m_res    <= modexp(mx_m, mx_e, mx_n);
    end else if (!mx_ready) begin
      if (mcnt == 0) begin
        mx_ready <= 1'b1;
        mx_c     <= m_res;
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  always @(posedge clk) if (mx_start) start_cnt++;

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); addr = a; wdata = d; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk); addr = a; rd = 1'b1;
    @(negedge clk); rd = 1'b0; d = rdata;
  endtask

  task automatic wait_irq();
    for (int i = 0; i < 400 && irq !== 1'b1; i++) @(negedge clk);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++; $display("FAIL done_timeout: irq=%b required 1", irq);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1; repeat (3) @(negedge clk); rst = 1'b0;
    tests_run++;
    if (irq !== 1'b0 || mx_start !== 1'b0) begin
      tests_failed++; $display("FAIL reset_outputs: irq=%b mx_start=%b required 0/0", irq, mx_start);
    end
    do_read(16'h0400, d); tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_status: got %h required 00", d); end
    do_read(16'h0000, d); tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_m: got %h required 00", d); end
    do_read(16'h0300, d); tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_c: got %h required 00", d); end
    do_read(16'h0404, d); tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_cyc: got %h required 00", d); end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    int s0;
    lat = 5;
    do_write(16'h0000, 8'h04); do_write(16'h0001, 8'h00);
    do_write(16'h0100, 8'h0D); do_write(16'h0101, 8'h00);
    do_write(16'h0200, 8'hF1); do_write(16'h0201, 8'h01);
    tests_run++;
    if (mx_m !== 16'h0004 || mx_e !== 16'h000D || mx_n !== 16'h01F1) begin
      tests_failed++;
      $display("FAIL operands: m=%h e=%h n=%h required 0004/000d/01f1", mx_m, mx_e, mx_n);
    end
    s0 = start_cnt;
    do_write(16'h0400, 8'h03);
    wait_irq();
    tests_run++;
    if (start_cnt - s0 != 1) begin
      tests_failed++; $display("FAIL start_pulse: cycles=%0d required 1", start_cnt - s0);
    end
    do_read(16'h0300, d); tests_run++;
    if (d !== 8'hBD) begin tests_failed++; $display("FAIL c_byte0: got %h required bd", d); end
    do_read(16'h0301, d); tests_run++;
    if (d !== 8'h01) begin tests_failed++; $display("FAIL c_byte1: got %h required 01", d); end
    do_read(16'h0400, d); tests_run++;
    if (d !== 8'h0A) begin tests_failed++; $display("FAIL done_status: got %h required 0a", d); end
  endtask

  task automatic test_busy_err();
    logic [7:0] d;
    logic [31:0] cyc;
    int s0;
    lat = 100;
    s0 = start_cnt;
    do_write(16'h0400, 8'h03);
    do_write(16'h0000, 8'h55);
    tests_run++;
    if (mx_m !== 16'h0004) begin
      tests_failed++; $display("FAIL busy_m_write: mx_m=%h required 0004", mx_m);
    end
    do_write(16'h0400, 8'h03);
    do_read(16'h0400, d); tests_run++;
    if (d !== 8'h0D) begin tests_failed++; $display("FAIL busy_err_status: got %h required 0d", d); end
    tests_run++;
    if (start_cnt - s0 != 1) begin
      tests_failed++; $display("FAIL busy_second_start: starts=%0d required 1", start_cnt - s0);
    end
    do_write(16'h0400, 8'h0A);
    do_read(16'h0400, d); tests_run++;
    if (d !== 8'h09) begin tests_failed++; $display("FAIL err_clear: got %h required 09", d); end
    wait_irq();
    for (int i = 0; i < 4; i++) begin
      do_read(16'(16'h0404 + i), d);
      cyc[8*i +: 8] = d;
    end
    tests_run++;
    if (cyc < 32'd98 || cyc > 32'd102) begin
      tests_failed++; $display("FAIL cyc_count: got %0d required 98..102", cyc);
    end
    do_read(16'h0000, d); tests_run++;
    if (d !== 8'h04) begin tests_failed++; $display("FAIL m_readback: got %h required 04", d); end
  endtask

  task automatic test_rego_and_reset();
    logic [7:0] d;
    do_write(16'h0400, 8'h03);
    do_read(16'h0400, d); tests_run++;
    if (d !== 8'h09) begin tests_failed++; $display("FAIL rego_status: got %h required 09", d); end
    do_read(16'h0404, d); tests_run++;
    if (d > 8'd6) begin tests_failed++; $display("FAIL rego_cyc: got %0d required <=6", d); end
    repeat (5) @(negedge clk);
    tests_run++;
    if (mx_ready !== 1'b0) begin
      tests_failed++; $display("FAIL whigh_reached: mx_ready=%b required 0", mx_ready);
    end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL rst_irq: got %b required 0", irq); end
    do_read(16'h0400, d); tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL rst_status: got %h required 00", d); end
    do_read(16'h0300, d); tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL rst_c: got %h required 00", d); end
    do_read(16'h0000, d); tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL rst_m: got %h required 00", d); end
    do_read(16'h0404, d); tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL rst_cyc: got %h required 00", d); end
  endtask

  task automatic test_bounds();
    logic [7:0] d;
    do_write(16'h0005, 8'hAA);
    do_read(16'h0005, d); tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL oor_0005: got %h required 00", d); end
    do_write(16'h07FF, 8'hAA);
    do_read(16'h07FF, d); tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL oor_07ff: got %h required 00", d); end
    do_write(16'h0002, 8'h77);
    tests_run++;
    if (mx_m !== 16'h0000) begin
      tests_failed++; $display("FAIL oor_m_clobber: mx_m=%h required 0000", mx_m);
    end
    do_write(16'h0001, 8'h12);
    @(negedge clk); addr = 16'h0001; wdata = 8'h34; wr = 1'b1; rd = 1'b1;
    @(negedge clk); wr = 1'b0; rd = 1'b0;
    tests_run++;
    if (rdata !== 8'h12) begin
      tests_failed++; $display("FAIL wr_rd_same: got %h required 12", rdata);
    end
    do_read(16'h0001, d); tests_run++;
    if (d !== 8'h34) begin tests_failed++; $display("FAIL wr_rd_commit: got %h required 34", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_err();
    test_rego_and_reset();
    test_bounds();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_rsa_mmio_bridge
`default_nettype wire
